// File: rtl/audio_i2s_tx_pkg.sv
// Shared audio types: stereo sample pair and I2S word-select levels.
package audio_i2s_tx_pkg;

    localparam int AUDIO_DW = 16;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    typedef struct packed {
        logic signed [AUDIO_DW-1:0] l;
        logic signed [AUDIO_DW-1:0] r;
    } stereo_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of stereo pairs; push is refused when full, pop when empty.
module audio_sample_fifo
    import audio_i2s_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  stereo_t       i_data,
    input  logic          i_pop,
    output stereo_t       o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    stereo_t       r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers stereo pairs and serializes them MSB first with the
// standard one-BCLK data delay; all link outputs change on BCLK falling edges.
module audio_i2s_tx
    import audio_i2s_tx_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DW,
    parameter int COUNT_BITS = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [COUNT_BITS-1:0]         bclk_div,
    input  logic signed [DATA_WIDTH-1:0]  in_l,
    input  logic signed [DATA_WIDTH-1:0]  in_r,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          i2s_bclk,
    output logic                          i2s_lrck,
    output logic                          i2s_sdata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int FRAME_BITS = 2 * DATA_WIDTH;
    localparam int KW         = $clog2(FRAME_BITS);
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic [COUNT_BITS-1:0] r_div_cnt;
    logic                  r_bclk;
    logic [KW-1:0]         r_bit;
    logic [FRAME_BITS-1:0] r_shift;
    stereo_t               r_hold;
    logic                  r_lrck;
    logic                  r_sdata;
    logic                  r_underrun;

    logic [COUNT_BITS-1:0] w_div_max;
    logic                  w_div_tc;
    logic                  w_fall;
    logic                  w_frame_start;
    stereo_t               w_pair_in;
    stereo_t               w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [LW-1:0]         w_level;

    assign w_pair_in = {in_l, in_r};

    audio_sample_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (in_valid),
        .i_data  (w_pair_in),
        .i_pop   (w_frame_start),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // A divisor of 0 behaves as 1; '>=' lets a shrunk divisor end the current
    // half-period at once, which is never shorter than the new half-period.
    assign w_div_max     = (bclk_div == '0) ? COUNT_BITS'(1) : bclk_div;
    assign w_div_tc      = (r_div_cnt >= (w_div_max - COUNT_BITS'(1)));
    assign w_fall        = enable && w_div_tc && r_bclk;
    assign w_frame_start = w_fall && (r_bit == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (!enable) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + COUNT_BITS'(1);
        end
    end

    // The shifter MSB always carries the bit for the coming falling edge; after
    // the last shift of a frame it holds R's LSB, emitted at the next k=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit      <= '0;
            r_shift    <= '0;
            r_hold     <= '0;
            r_lrck     <= LRCK_RIGHT;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (!enable) begin
                r_bit   <= '0;
                r_shift <= '0;
                r_lrck  <= LRCK_RIGHT;
                r_sdata <= 1'b0;
            end else if (w_fall) begin
                r_bit   <= (r_bit == KW'(FRAME_BITS - 1)) ? '0 : r_bit + KW'(1);
                r_lrck  <= (r_bit >= KW'(DATA_WIDTH)) ? LRCK_RIGHT : LRCK_LEFT;
                r_sdata <= r_shift[FRAME_BITS-1];
                if (r_bit == '0) begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_hold  <= w_head;
                    end else begin
                        r_shift    <= r_hold;
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign i2s_bclk   = r_bclk;
    assign i2s_lrck   = r_lrck;
    assign i2s_sdata  = r_sdata;
    assign underrun   = r_underrun;
    assign in_ready   = !w_full;
    assign fifo_level = w_level;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: accepted pairs are queued by the stimulus,
// and a monitor replays the I2S frame rules bit by bit against the link.
module tb_audio_i2s_tx;

    localparam int DW    = 16;
    localparam int CB    = 10;
    localparam int DEPTH = 4;
    localparam int FB    = 2 * DW;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 enable = 1'b0;
    logic [CB-1:0]        bclk_div = CB'(2);
    logic signed [DW-1:0] in_l = '0;
    logic signed [DW-1:0] in_r = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 i2s_bclk;
    logic                 i2s_lrck;
    logic                 i2s_sdata;
    logic                 underrun;
    logic [2:0]           fifo_level;

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .DATA_WIDTH (DW),
        .COUNT_BITS (CB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .bclk_div   (bclk_div),
        .in_l       (in_l),
        .in_r       (in_r),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_sdata  (i2s_sdata),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    typedef struct {
        logic [FB-1:0] w;
        int            acc;
    } ent_t;

    ent_t          q[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            m_k = 0;
    int            hcnt = 0;
    logic [FB-1:0] m_cur = '0;
    logic [FB-1:0] m_hold = '0;
    logic          p_bclk = 1'b0;
    logic          p_lrck = 1'b1;
    logic          p_sd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: one sample per clk, 1 time unit after the rising edge.
    always @(posedge clk) begin
        int   mx;
        int   k;
        logic exp_sd;
        logic exp_un;
        logic fall;
        #1;
        if (!reset_n) begin
            m_k    = 0;
            hcnt   = 0;
            m_cur  = '0;
            m_hold = '0;
            p_bclk = 1'b0;
            p_lrck = 1'b1;
            p_sd   = 1'b0;
        end else begin
            mx = (bclk_div == '0) ? 1 : int'(bclk_div);
            if (!enable) begin
                chk("idle_bclk", i2s_bclk, 1'b0);
                chk("idle_lrck", i2s_lrck, 1'b1);
                chk("idle_sdata", i2s_sdata, 1'b0);
                chk("idle_underrun", underrun, 1'b0);
                m_k   = 0;
                hcnt  = 0;
                m_cur = '0;
            end else begin
                hcnt++;
                fall = p_bclk && !i2s_bclk;
                if (i2s_bclk != p_bclk) begin
                    chk("bclk_half_period", hcnt, mx);
                    hcnt = 0;
                end
                if (fall) begin
                    k = m_k;
                    if (k == 0) begin
                        exp_sd = m_cur[0];
                        if (q.size() > 0 && q[0].acc < cyc) begin
                            m_hold = q[0].w;
                            void'(q.pop_front());
                            exp_un = 1'b0;
                        end else begin
                            exp_un = 1'b1;
                        end
                        m_cur = m_hold;
                    end else begin
                        exp_sd = m_cur[FB-k];
                        exp_un = 1'b0;
                    end
                    chk("lrck", i2s_lrck, (k >= DW));
                    chk("sdata", i2s_sdata, exp_sd);
                    chk("underrun", underrun, exp_un);
                    m_k = (k + 1) % FB;
                end else begin
                    chk("underrun_quiet", underrun, 1'b0);
                    chk("lrck_stable", i2s_lrck, p_lrck);
                    chk("sdata_stable", i2s_sdata, p_sd);
                end
            end
            chk("fifo_level", fifo_level, q.size());
            chk("in_ready", in_ready, (q.size() != DEPTH));
            p_bclk = i2s_bclk;
            p_lrck = i2s_lrck;
            p_sd   = i2s_sdata;
        end
    end

    // Called at a falling clk edge; returns at the next one.
    task automatic step(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        in_valid = v;
        in_l     = l;
        in_r     = r;
        if (v && q.size() != DEPTH) q.push_back('{w: {l, r}, acc: cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    task automatic run_random(input int n, input int prob);
        for (int i = 0; i < n; i++)
            step(($urandom % prob) == 0, DW'($urandom), DW'($urandom));
    endtask

    // Stops one clk before the rising edge that is the k=0 frame-start edge.
    task automatic wait_k0();
        int mx;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            mx = (bclk_div == '0) ? 1 : int'(bclk_div);
            if (enable && p_bclk && (hcnt + 1 >= mx) && m_k == 0) hit = 1'b1;
            else step(1'b0, '0, '0);
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL wait_k0: no frame start within cycle budget");
        end
    endtask

    task automatic wait_after_k(input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            if (m_k == target) hit = 1'b1;
            else step(1'b0, '0, '0);
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL wait_after_k: bit index %0d not reached", target);
        end
    endtask

    initial begin
        // Reset values, applied with no clock edge
        #1 reset_n = 1'b0;
        #2;
        chk("rst_bclk", i2s_bclk, 1'b0);
        chk("rst_lrck", i2s_lrck, 1'b1);
        chk("rst_sdata", i2s_sdata, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_level", fifo_level, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Basic frame
        bclk_div = CB'(2);
        step(1'b1, 16'hA55A, 16'h8001);
        enable = 1'b1;
        idle(64 * 2 * 2 + 16);

        // Asynchronous reset mid-frame with data queued
        step(1'b1, 16'h0F0F, 16'hF00F);
        step(1'b1, 16'h7FFF, 16'h8000);
        idle(40);
        #2 reset_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_bclk", i2s_bclk, 1'b0);
        chk("midrst_lrck", i2s_lrck, 1'b1);
        chk("midrst_sdata", i2s_sdata, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_level", fifo_level, 0);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Underrun from empty FIFO, then a single pair repeated
        bclk_div = CB'(1);
        enable = 1'b1;
        idle(64 * 2 + 8);
        step(1'b1, 16'h1234, 16'h5678);
        idle(64 * 4);

        // Full FIFO and backpressure while idle
        enable = 1'b0;
        idle(2);
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), DW'($urandom));
        chk("full_level", fifo_level, DEPTH);
        chk("full_ready", in_ready, 1'b0);
        bclk_div = CB'(3);
        enable = 1'b1;
        idle(64 * 3 * 6 + 20);

        // Push on the pop edge: empty FIFO, then level 2
        wait_k0();
        step(1'b1, 16'hCAFE, 16'hBEEF);
        chk("simul_underrun", underrun, 1'b1);
        chk("simul_level1", fifo_level, 1);
        step(1'b1, 16'h1111, 16'h2222);
        wait_k0();
        step(1'b1, 16'h3333, 16'h4444);
        chk("simul_level2", fifo_level, 2);

        // Abort after k=7, then restart with divisor 0
        wait_after_k(8);
        enable = 1'b0;
        step(1'b0, '0, '0);
        chk("abort_bclk", i2s_bclk, 1'b0);
        chk("abort_lrck", i2s_lrck, 1'b1);
        chk("abort_sdata", i2s_sdata, 1'b0);
        bclk_div = CB'(0);
        enable = 1'b1;
        idle(64 * 3 + 10);

        // Randomized traffic with divisor changes between runs
        for (int p = 0; p < 6; p++) begin
            enable = 1'b0;
            idle(3);
            bclk_div = CB'($urandom_range(0, 4));
            enable = 1'b1;
            run_random(300 + int'($urandom % 400), 2 + int'($urandom % 5));
        end
        enable = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
